// File: rtl/fwd_track_unit.sv
// Forwarding and load-use hazard unit. It keeps a private DEPTH-stage record
// of in-flight register writes and derives forward selects and stalls from it.
module fwd_track_unit #(
    parameter  int NUM_PORTS = 2,
    parameter  int DEPTH     = 3,
    parameter  int AW        = 5,
    parameter  int LOAD_LAT  = 2,
    parameter  int CNT_W     = 16,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_regwrite,
    input  logic                      issue_is_load,
    input  logic [AW-1:0]             issue_rd,
    input  logic [NUM_PORTS*AW-1:0]   rs_addr,
    input  logic [NUM_PORTS-1:0]      rs_used,
    input  logic                      hold,
    input  logic                      flush,
    output logic [NUM_PORTS*SELW-1:0] fwd_sel,
    output logic                      stall_out,
    output logic [15:0]               stall_count,
    output logic [SELW-1:0]           inflight
);

    function automatic logic [SELW-1:0] popcount_f(input logic [DEPTH:1] v);
        logic [SELW-1:0] c;
        c = {SELW{1'b0}};
        for (int i = 1; i <= DEPTH; i++) begin
            c = c + SELW'(v[i]);
        end
        return c;
    endfunction

    logic [DEPTH:1]  st_valid_r;
    logic [DEPTH:1]  st_wr_r;
    logic [DEPTH:1]  st_ld_r;
    logic [AW-1:0]   st_rd_r [1:DEPTH];

    logic [DEPTH:1]  nxt_valid_s;
    logic [DEPTH:1]  nxt_wr_s;
    logic [DEPTH:1]  nxt_ld_s;
    logic [AW-1:0]   nxt_rd_s [1:DEPTH];

    logic            accept_s;
    logic            stall_s;
    logic [SELW-1:0] port_sel_s [NUM_PORTS];
    logic            port_ld_s  [NUM_PORTS];
    logic [NUM_PORTS*SELW-1:0] fwd_sel_s;

    logic [CNT_W-1:0] stall_count_r;
    logic [SELW-1:0]  inflight_r;

    // Priority search per port: scanning from oldest to youngest lets the youngest writer win.
    always_comb begin
        fwd_sel_s = {(NUM_PORTS*SELW){1'b0}};
        stall_s   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_sel_s[p] = {SELW{1'b0}};
            port_ld_s[p]  = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                logic hit;
                hit = st_valid_r[k] & st_wr_r[k] & rs_used[p]
                    & (st_rd_r[k] == rs_addr[p*AW +: AW])
                    & (rs_addr[p*AW +: AW] != {AW{1'b0}});
                port_sel_s[p] = hit ? SELW'(k) : port_sel_s[p];
                port_ld_s[p]  = hit ? st_ld_r[k] : port_ld_s[p];
            end
            fwd_sel_s[p*SELW +: SELW] = port_sel_s[p];
            // A load is usable only once it reaches LOAD_LAT; anything younger must wait.
            if (port_ld_s[p] && (port_sel_s[p] != {SELW{1'b0}}) &&
                (int'(port_sel_s[p]) < LOAD_LAT)) begin
                stall_s = 1'b1;
            end else begin
                stall_s = stall_s;
            end
        end
    end

    // Next contents of the record pipeline.
    always_comb begin
        accept_s    = issue_valid & ~stall_s & ~flush;
        nxt_valid_s = st_valid_r;
        nxt_wr_s    = st_wr_r;
        nxt_ld_s    = st_ld_r;
        for (int k = 1; k <= DEPTH; k++) begin
            nxt_rd_s[k] = st_rd_r[k];
        end
        if (hold) begin
            nxt_valid_s = st_valid_r;
        end else begin
            nxt_valid_s[1] = accept_s;
            nxt_wr_s[1]    = issue_regwrite;
            nxt_ld_s[1]    = issue_is_load;
            nxt_rd_s[1]    = issue_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                nxt_valid_s[k] = st_valid_r[k-1];
                nxt_wr_s[k]    = st_wr_r[k-1];
                nxt_ld_s[k]    = st_ld_r[k-1];
                nxt_rd_s[k]    = st_rd_r[k-1];
            end
        end
    end

    // Record pipeline, in-flight count and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid_r    <= {DEPTH{1'b0}};
            st_wr_r       <= {DEPTH{1'b0}};
            st_ld_r       <= {DEPTH{1'b0}};
            for (int k = 1; k <= DEPTH; k++) begin
                st_rd_r[k] <= {AW{1'b0}};
            end
            stall_count_r <= {CNT_W{1'b0}};
            inflight_r    <= {SELW{1'b0}};
        end else begin
            st_valid_r <= nxt_valid_s;
            st_wr_r    <= nxt_wr_s;
            st_ld_r    <= nxt_ld_s;
            for (int k = 1; k <= DEPTH; k++) begin
                st_rd_r[k] <= nxt_rd_s[k];
            end
            inflight_r <= popcount_f(nxt_valid_s & nxt_wr_s);
            if (!hold && stall_s && issue_valid && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_W'(1'b1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign fwd_sel     = fwd_sel_s;
    assign stall_out   = stall_s;
    assign stall_count = 16'(stall_count_r);
    assign inflight    = inflight_r;

endmodule

// File: tb/tb_fwd_track_unit.sv
// Directed bench for fwd_track_unit; a second narrow-counter instance shares
// the same inputs so counter saturation is reachable in a short run.
module tb_fwd_track_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_regwrite, issue_is_load;
    logic [4:0]  issue_rd;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_used;
    logic        hold, flush;
    logic [3:0]  fwd_sel,     fwd_sel_b;
    logic        stall_out,   stall_b;
    logic [15:0] stall_count, stall_count_b;
    logic [1:0]  inflight,    inflight_b;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fwd_track_unit dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
        .issue_is_load(issue_is_load), .issue_rd(issue_rd), .rs_addr(rs_addr),
        .rs_used(rs_used), .hold(hold), .flush(flush), .fwd_sel(fwd_sel),
        .stall_out(stall_out), .stall_count(stall_count), .inflight(inflight)
    );

    fwd_track_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
        .issue_is_load(issue_is_load), .issue_rd(issue_rd), .rs_addr(rs_addr),
        .rs_used(rs_used), .hold(hold), .flush(flush), .fwd_sel(fwd_sel_b),
        .stall_out(stall_b), .stall_count(stall_count_b), .inflight(inflight_b)
    );

    task automatic drive(input logic iv, input logic wr, input logic ld, input logic [4:0] rd,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
                         input logic h, input logic f);
        issue_valid = iv; issue_regwrite = wr; issue_is_load = ld; issue_rd = rd;
        rs_addr = {a1, a0}; rs_used = used; hold = h; flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd4, 2'b11, 1'b0, 1'b0);
        #1;
        total++; if (fwd_sel !== 4'd0) $display("FAIL reset_fwd_sel got %0d exp 0", fwd_sel); else passed++;
        total++; if (stall_out !== 1'b0) $display("FAIL reset_stall got %0d exp 0", stall_out); else passed++;
        total++; if (inflight !== 2'd0) $display("FAIL reset_inflight got %0d exp 0", inflight); else passed++;
        total++; if (stall_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", stall_count); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 2'b11, 1'b0, 1'b0);
        #1;
        total++; if (fwd_sel[1:0] !== 2'd1) $display("FAIL b2b_stage1 got %0d exp 1", fwd_sel[1:0]); else passed++;
        total++; if (fwd_sel[3:2] !== 2'd1) $display("FAIL b2b_port1 got %0d exp 1", fwd_sel[3:2]); else passed++;
        total++; if (stall_out !== 1'b0) $display("FAIL b2b_stall got %0d exp 0", stall_out); else passed++;
        total++; if (inflight !== 2'd1) $display("FAIL b2b_inflight got %0d exp 1", inflight); else passed++;
        tick();
        total++; if (fwd_sel[1:0] !== 2'd2) $display("FAIL b2b_stage2 got %0d exp 2", fwd_sel[1:0]); else passed++;
        tick();
        total++; if (fwd_sel[1:0] !== 2'd3) $display("FAIL b2b_stage3 got %0d exp 3", fwd_sel[1:0]); else passed++;
        tick();
        total++; if (fwd_sel[1:0] !== 2'd0) $display("FAIL b2b_retired got %0d exp 0", fwd_sel[1:0]); else passed++;
        total++; if (inflight !== 2'd0) $display("FAIL b2b_inflight_end got %0d exp 0", inflight); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd8, 2'b10, 1'b0, 1'b0);
        #1;
        total++; if (stall_out !== 1'b1) $display("FAIL lu_stall got %0d exp 1", stall_out); else passed++;
        total++; if (fwd_sel[3:2] !== 2'd1) $display("FAIL lu_sel1 got %0d exp 1", fwd_sel[3:2]); else passed++;
        tick();
        total++; if (stall_out !== 1'b0) $display("FAIL lu_stall_clear got %0d exp 0", stall_out); else passed++;
        total++; if (fwd_sel[3:2] !== 2'd2) $display("FAIL lu_sel2 got %0d exp 2", fwd_sel[3:2]); else passed++;
        total++; if (stall_count !== 16'd1) $display("FAIL lu_count got %0d exp 1", stall_count); else passed++;
        total++; if (inflight !== 2'd1) $display("FAIL lu_bubble got %0d exp 1", inflight); else passed++;
        tick();
        total++; if (inflight !== 2'd2) $display("FAIL lu_issued got %0d exp 2", inflight); else passed++;
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
        #1;
        total++; if (fwd_sel[1:0] !== 2'd1) $display("FAIL young_alu got %0d exp 1", fwd_sel[1:0]); else passed++;
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
        #1;
        total++; if (fwd_sel[1:0] !== 2'd1) $display("FAIL young_shadow_sel got %0d exp 1", fwd_sel[1:0]); else passed++;
        total++; if (stall_out !== 1'b0) $display("FAIL young_shadow_stall got %0d exp 0", stall_out); else passed++;
    endtask

    task automatic test_r0_unused();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0);
        #1;
        total++; if (fwd_sel !== 4'd0) $display("FAIL r0_sel got %0d exp 0", fwd_sel); else passed++;
        total++; if (inflight !== 2'd1) $display("FAIL r0_tracked got %0d exp 1", inflight); else passed++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 2'b10, 1'b0, 1'b0);
        #1;
        total++; if (fwd_sel[1:0] !== 2'd0) $display("FAIL unused_sel got %0d exp 0", fwd_sel[1:0]); else passed++;
        total++; if (fwd_sel[3:2] !== 2'd1) $display("FAIL used_sel got %0d exp 1", fwd_sel[3:2]); else passed++;
    endtask

    task automatic test_hold_flush();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd8, 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (stall_out !== 1'b1) $display("FAIL hold_stall%0d got %0d exp 1", i, stall_out); else passed++;
            total++; if (fwd_sel[3:2] !== 2'd1) $display("FAIL hold_sel%0d got %0d exp 1", i, fwd_sel[3:2]); else passed++;
            total++; if (stall_count !== 16'd0) $display("FAIL hold_count%0d got %0d exp 0", i, stall_count); else passed++;
        end
        hold = 1'b0;
        tick();
        total++; if (stall_count !== 16'd1) $display("FAIL hold_release_count got %0d exp 1", stall_count); else passed++;
        total++; if (fwd_sel[3:2] !== 2'd2) $display("FAIL hold_release_sel got %0d exp 2", fwd_sel[3:2]); else passed++;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd12, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd12, 5'd0, 2'b01, 1'b0, 1'b0);
        #1;
        total++; if (fwd_sel[1:0] !== 2'd0) $display("FAIL flush_sel got %0d exp 0", fwd_sel[1:0]); else passed++;
        total++; if (inflight !== 2'd0) $display("FAIL flush_inflight got %0d exp 0", inflight); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0);
        #1;
        total++; if (stall_out !== 1'b1) $display("FAIL mid_stall got %0d exp 1", stall_out); else passed++;
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        total++; if (inflight !== 2'd3) $display("FAIL mid_inflight got %0d exp 3", inflight); else passed++;
        total++; if (stall_count !== 16'd1) $display("FAIL mid_count got %0d exp 1", stall_count); else passed++;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01, 1'b1, 1'b1);
        #1;
        total++; if (fwd_sel[1:0] !== 2'd2) $display("FAIL mid_pre_sel got %0d exp 2", fwd_sel[1:0]); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (inflight !== 2'd0) $display("FAIL mid_rst_inflight got %0d exp 0", inflight); else passed++;
        total++; if (fwd_sel !== 4'd0) $display("FAIL mid_rst_sel got %0d exp 0", fwd_sel); else passed++;
        total++; if (stall_count !== 16'd0) $display("FAIL mid_rst_count got %0d exp 0", stall_count); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        // A dependent load every cycle stalls on every other cycle.
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd8, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 28; i++) tick();
        total++; if (stall_count_b !== 16'd14) $display("FAIL sat_pre got %0d exp 14", stall_count_b); else passed++;
        total++; if (stall_count !== 16'd14) $display("FAIL wide_pre got %0d exp 14", stall_count); else passed++;
        for (int i = 0; i < 12; i++) tick();
        total++; if (stall_count_b !== 16'd15) $display("FAIL sat_hold got %0d exp 15", stall_count_b); else passed++;
        total++; if (stall_count !== 16'd20) $display("FAIL wide_count got %0d exp 20", stall_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest();
        test_r0_unused();
        test_hold_flush();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
